// File: rtl/ram.sv
// ============================================================================
// Module      : ram
// Description : Single-port MEM_DEPTH x 8 synchronous RAM driven by 10-bit
//               command words {opcode[1:0], payload[7:0]} from an SPI slave.
//               Define RAM_MEM_CLEAR_EN to also zero MEM during reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE+1:0] din,
  input  logic                 rx_valid,
  output logic [ADDR_SIZE-1:0] dout,
  output logic                 tx_valid
);

  localparam logic [1:0] c_OP_SET_WR_ADDR = 2'b00;
  localparam logic [1:0] c_OP_WRITE_DATA  = 2'b01;
  localparam logic [1:0] c_OP_SET_RD_ADDR = 2'b10;
  localparam logic [1:0] c_OP_READ_DATA   = 2'b11;

  logic [ADDR_SIZE-1:0] MEM [0:MEM_DEPTH-1];
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;

  wire [1:0]           w_opcode  = din[ADDR_SIZE+1:ADDR_SIZE];
  wire [ADDR_SIZE-1:0] w_payload = din[ADDR_SIZE-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      dout     <= '0;
      tx_valid <= 1'b0;
`ifdef RAM_MEM_CLEAR_EN
      for (int i = 0; i < MEM_DEPTH; i++) begin
        MEM[i] <= '0;
      end
`endif
    end else begin
      // tx_valid is a one-cycle strobe, re-asserted only by back-to-back reads
      tx_valid <= 1'b0;
      if (rx_valid) begin
        case (w_opcode)
          c_OP_SET_WR_ADDR: wr_addr <= w_payload;
          c_OP_WRITE_DATA:  MEM[wr_addr] <= w_payload;
          c_OP_SET_RD_ADDR: rd_addr <= w_payload;
          c_OP_READ_DATA: begin
            dout     <= MEM[rd_addr];
            tx_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram.sv
// ============================================================================
// Module      : tb_ram
// Description : Self-checking bench for ram against an array-based command
//               model; honours RAM_MEM_CLEAR_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram;

  logic       clk;
  logic       rst_n;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;

  ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .rx_valid (rx_valid),
    .dout     (dout),
    .tx_valid (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] mem_m [0:255];
  logic [7:0] wr_m, rd_m, dout_m;
  logic       tx_m;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  // Apply one word across one rising edge, advance the model, compare outputs.
  task automatic step(input logic rst_v, input logic vld, input logic [1:0] op,
                      input logic [7:0] pl, input string tag);
    @(negedge clk);
    rst_n    = rst_v;
    rx_valid = vld;
    din      = {op, pl};
    @(posedge clk);
    #1;
    if (!rst_v) begin
      wr_m = 8'h00; rd_m = 8'h00; dout_m = 8'h00; tx_m = 1'b0;
`ifdef RAM_MEM_CLEAR_EN
      for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
`endif
    end else begin
      tx_m = 1'b0;
      if (vld) begin
        if (op == 2'd0) wr_m = pl;
        else if (op == 2'd1) mem_m[wr_m] = pl;
        else if (op == 2'd2) rd_m = pl;
        else begin
          dout_m = mem_m[rd_m];
          tx_m   = 1'b1;
        end
      end
    end
    check({tag, ".dout"}, dout, dout_m);
    check({tag, ".tx_valid"}, {7'd0, tx_valid}, {7'd0, tx_m});
  endtask

  initial begin
    logic [7:0] a, d;
    rst_n = 1'b0; rx_valid = 1'b0; din = '0;
    wr_m = 8'h00; rd_m = 8'h00; dout_m = 8'h00; tx_m = 1'b0;
    for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;

    // Reset state
    step(1'b0, 1'b0, 2'd0, 8'h00, "reset0");
    step(1'b0, 1'b1, 2'd3, 8'hFF, "reset1");
    check("reset.wr_addr", dut.wr_addr, 8'h00);
    check("reset.rd_addr", dut.rd_addr, 8'h00);

    // Preload MEM[i] = i in both DUT and model
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      dut.MEM[i] = 8'(i);
      mem_m[i]   = 8'(i);
    end

    // Basic read of address 5
    step(1'b1, 1'b1, 2'd2, 8'h05, "rd05.set");
    step(1'b1, 1'b1, 2'd3, 8'($urandom), "rd05.read");
    check("rd05.value", dout, 8'h05);

    // Sweep all addresses with alternating set/read
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 1'b1, 2'd2, 8'(i), "sweep.set");
      step(1'b1, 1'b1, 2'd3, 8'($urandom), "sweep.read");
    end

    // Same sweep with rx_valid low after a reset: outputs must stay idle
    step(1'b0, 1'b0, 2'd0, 8'h00, "reset2");
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 1'b0, 2'd2, 8'(i), "idle.set");
      step(1'b1, 1'b0, 2'd3, 8'($urandom), "idle.read");
    end
    check("idle.rd_addr", dut.rd_addr, 8'h00);
    check("idle.wr_addr", dut.wr_addr, 8'h00);

    // Directed write then read back
    step(1'b1, 1'b1, 2'd0, 8'h3C, "wr3c.addr");
    step(1'b1, 1'b1, 2'd1, 8'hA7, "wr3c.data");
    step(1'b1, 1'b1, 2'd2, 8'h3C, "wr3c.rdaddr");
    step(1'b1, 1'b1, 2'd3, 8'($urandom), "wr3c.read");
    check("wr3c.value", dout, 8'hA7);

    // Random write/read-back iterations
    for (int k = 0; k < 25; k++) begin
      a = 8'($urandom);
      d = 8'($urandom);
      step(1'b1, 1'b1, 2'd0, a, "rndwr.addr");
      step(1'b1, 1'b1, 2'd1, d, "rndwr.data");
      step(1'b1, 1'b1, 2'd2, a, "rndwr.rdaddr");
      step(1'b1, 1'b1, 2'd3, 8'($urandom), "rndwr.read");
      check("rndwr.value", dout, d);
    end

    // Random command stream with stalls, including back-to-back reads
    for (int k = 0; k < 300; k++) begin
      step(1'b1, 1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom), "rndcmd");
    end

    // Write attempt with rx_valid low must not disturb MEM[0x3C]
    step(1'b1, 1'b0, 2'd0, 8'h3C, "nowr.addr");
    step(1'b1, 1'b0, 2'd1, 8'h55, "nowr.data");
    check("nowr.mem3c", dut.MEM[8'h3C], mem_m[8'h3C]);
    check("nowr.wr_addr", dut.wr_addr, wr_m);

    // Reset mid-sequence returns the read address to 0
    step(1'b1, 1'b1, 2'd2, 8'h20, "midrst.set");
    step(1'b0, 1'b1, 2'd3, 8'h00, "midrst.reset");
    step(1'b1, 1'b1, 2'd3, 8'($urandom), "midrst.read");
`ifdef RAM_MEM_CLEAR_EN
    check("midrst.mem0", dout, 8'h00);
`else
    check("midrst.mem0", dout, mem_m[0]);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram.md
# ram

Single-port 256×8 synchronous RAM driven by a 10-bit command/data word: two opcode bits plus an 8-bit payload. It sits behind the SPI slave. The slave delivers one word per `rx_valid` cycle. The RAM returns read data on `dout`, qualified by `tx_valid`, for the slave to shift out. Write and read addresses are latched by separate commands and held in independent registers.

## Interface
- `MEM_DEPTH`, 256, number of 8-bit words.
- `ADDR_SIZE`, 8, address width; payload width equals `ADDR_SIZE`.
- `clk`  in  1  rising-edge clock for all state.
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `din`  in  `ADDR_SIZE+2`  `[9:8]` opcode, `[7:0]` payload (address or data).
- `rx_valid`  in  1  `din` valid this cycle; the command executes only when high.
- `dout`  out  8  registered read data.
- `tx_valid`  out  1  registered; high while `dout` carries data from a read-data command.

## Operation
- Storage: array named `MEM`, `[7:0] MEM [0:MEM_DEPTH-1]`. The name is fixed because benches preload it hierarchically.
- Internal registers: `wr_addr[7:0]` and `rd_addr[7:0]`.
- Commands execute at a rising edge where `rx_valid`=1, decoded from `din[9:8]`:
  - 00, set write address: `wr_addr <= din[7:0]`; `tx_valid <= 0`.
  - 01, write data: `MEM[wr_addr] <= din[7:0]`; `tx_valid <= 0`.
  - 10, set read address: `rd_addr <= din[7:0]`; `tx_valid <= 0`.
  - 11, read data: `dout <= MEM[rd_addr]`; `tx_valid <= 1`. Payload is ignored (dummy byte).
- When `rx_valid`=0:
  - No command executes.
  - `MEM`, `wr_addr`, `rd_addr` and `dout` hold.
  - `tx_valid <= 0`.
- Addresses are 8-bit, with no wrap or auto-increment. `wr_addr` and `rd_addr` persist until rewritten. Repeated 01 commands write the same location.
- Repeated 11 commands re-read `MEM[rd_addr]`; `tx_valid` stays 1 for each consecutive one.
- There is no state machine. The block is purely command-driven, so any opcode order is legal.

## Timing
- Reset: on a rising edge with `rst_n`=0, `dout`=0x00, `tx_valid`=0, `wr_addr`=0, `rd_addr`=0. Reset overrides `rx_valid`/`din` in that cycle.
- `MEM` is not cleared by reset unless `RAM_MEM_CLEAR_EN` is defined.
- Latency:
  - A read-data command sampled at edge N presents data on `dout` and `tx_valid`=1 after edge N.
  - `tx_valid` falls after the next edge unless another 11 is accepted.
- Write-to-read: a 01 at edge N is visible to an 11 at edge N+1 or later when the addresses match. No bypass is needed because only one command exists per cycle.
- Reset mid-sequence: latched addresses return to 0. A following 11 without a new 10 reads `MEM[0]`.
- `rx_valid` dropping mid-sequence stalls the sequence; the next accepted word continues with the latched addresses.

## Configuration
- `RAM_MEM_CLEAR_EN` defined: the synchronous reset also writes 0x00 to every `MEM` entry in the reset cycle.
- `RAM_MEM_CLEAR_EN` not defined: `MEM` retains its contents through reset; only registers and outputs reset.

## Test plan
- Reset, then preload `MEM[i]=i`. With `rx_valid`=1, send 10/0x05 then 11/random -> `dout`=0x05 and `tx_valid`=1 after the 11 edge; `tx_valid`=0 after the 10 edge.
- Sweep addresses 0..255 with alternating 10/addr and 11/dummy, `rx_valid`=1 -> `dout` = 0x00..0xFF in order; `tx_valid` toggles 0/1 every cycle.
- Same sweep with `rx_valid`=0 -> `dout` stays 0x00 and `tx_valid` stays 0; `MEM` and the address registers are unchanged.
- Write path: 00/0x3C, 01/0xA7, 10/0x3C, 11/dummy, `rx_valid`=1 -> `dout`=0xA7 with `tx_valid`=1. Repeat with random addr/data for 25 iterations, each returning the written byte.
- Write path with `rx_valid`=0 (00/0x3C, 01/0x55) -> `MEM[0x3C]` keeps its prior value and outputs stay idle.
- Reset after 10/0x20 -> `dout`=0, `tx_valid`=0. A following 11 returns `MEM[0]`: 0x00 if `RAM_MEM_CLEAR_EN` is defined, otherwise the preloaded value.
